// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch queue: FSM encoding and default sizing.
package if_pkg;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  localparam int unsigned IF_DEPTH    = 4;
  localparam logic [31:0] IF_RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs; flush empties it in one cycle.
module inst_fifo
  import if_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = IF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // NOTE: the storage array is deliberately not reset; only pointers and count
  // define validity, and leaving the array reset-free keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_fetch_q.sv
// Instruction fetch front end: issues one SRAM read at a time and queues the results for decode.
module if_fetch_q
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = IF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REDIRECT_VALID,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  output logic              SRAM_INST_CE,
  output logic [ADDR_W-1:0] SRAM_INST_VADDR,
  input  logic              SRAM_INST_GNT,
  input  logic              SRAM_INST_RVALID,
  input  logic [DATA_W-1:0] SRAM_INST_RDATA,
  output logic              INST_VALID,
  input  logic              INST_READY,
  output logic [ADDR_W-1:0] INST_PC,
  output logic [DATA_W-1:0] INST_DATA
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e               r_state;
  fetch_state_e               w_next_state;
  logic [ADDR_W-1:0]          r_fetch_pc;
  logic [ADDR_W-1:0]          w_next_pc;
  logic [ADDR_W-1:0]          r_inflight_pc;
  logic [ADDR_W-1:0]          w_redirect_pc;
  logic                       w_capture;
  logic                       w_push;
  logic                       w_pop;
  logic [CNT_W-1:0]           w_count;
  logic [ADDR_W+DATA_W-1:0]   w_head;
  logic                       w_unused_redirect_lsb;

  assign w_redirect_pc         = {REDIRECT_PC[ADDR_W-1:2], 2'b00};
  assign w_unused_redirect_lsb = ^REDIRECT_PC[1:0];

  // RST gates CE so no request escapes while reset is held, even though state already reads FETCH.
  assign SRAM_INST_CE    = RST && (r_state == S_FETCH) && (w_count < CNT_W'(DEPTH));
  assign SRAM_INST_VADDR = r_fetch_pc;

  assign INST_VALID = (w_count != '0);
  assign INST_PC    = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign INST_DATA  = w_head[DATA_W-1:0];
  assign w_pop      = INST_VALID && INST_READY;

  // NOTE: every output of this block gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_fetch_pc;
    w_capture    = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (SRAM_INST_CE && SRAM_INST_GNT) begin
          w_capture    = 1'b1;
          w_next_pc    = r_fetch_pc + ADDR_W'(4);
          w_next_state = REDIRECT_VALID ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (SRAM_INST_RVALID) begin
          w_push       = !REDIRECT_VALID;
          w_next_state = S_FETCH;
        end else if (REDIRECT_VALID) begin
          w_next_state = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (SRAM_INST_RVALID) w_next_state = S_FETCH;
      end
      default: w_next_state = S_FETCH;
    endcase
    if (REDIRECT_VALID) w_next_pc = w_redirect_pc;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= S_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
    end else begin
      r_state    <= w_next_state;
      r_fetch_pc <= w_next_pc;
      if (w_capture) r_inflight_pc <= r_fetch_pc;
    end
  end

  inst_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .i_push  (w_push),
    .i_wdata ({r_inflight_pc, SRAM_INST_RDATA}),
    .i_pop   (w_pop),
    .i_flush (REDIRECT_VALID),
    .o_rdata (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_if_fetch_q.sv
// Self-checking bench for if_fetch_q: directed scenarios plus random traffic against a transaction-level model.
module tb_if_fetch_q;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REDIRECT_VALID = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        SRAM_INST_CE;
  logic [31:0] SRAM_INST_VADDR;
  logic        SRAM_INST_GNT = 1'b0;
  logic        SRAM_INST_RVALID = 1'b0;
  logic [31:0] SRAM_INST_RDATA = '0;
  logic        INST_VALID;
  logic        INST_READY = 1'b0;
  logic [31:0] INST_PC;
  logic [31:0] INST_DATA;

  int n_vec = 0;
  int n_err = 0;

  // Model: one outstanding request (possibly stale), next fetch address, and the queue contents.
  bit          m_busy;
  bit          m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_inflight;
  ent_t        m_q[$];

  if_fetch_q #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .REDIRECT_VALID   (REDIRECT_VALID),
    .REDIRECT_PC      (REDIRECT_PC),
    .SRAM_INST_CE     (SRAM_INST_CE),
    .SRAM_INST_VADDR  (SRAM_INST_VADDR),
    .SRAM_INST_GNT    (SRAM_INST_GNT),
    .SRAM_INST_RVALID (SRAM_INST_RVALID),
    .SRAM_INST_RDATA  (SRAM_INST_RDATA),
    .INST_VALID       (INST_VALID),
    .INST_READY       (INST_READY),
    .INST_PC          (INST_PC),
    .INST_DATA        (INST_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_busy     = 1'b0;
    m_stale    = 1'b0;
    m_pc       = RST_PC;
    m_inflight = '0;
    m_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    SRAM_INST_GNT = 1'b0; SRAM_INST_RVALID = 1'b0; INST_READY = 1'b0;
    REDIRECT_VALID = 1'b0; REDIRECT_PC = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    #1;
  endtask

  // Compare visible outputs with the model, apply one cycle of inputs, advance model and DUT.
  task automatic step(input logic gnt, input logic rv, input logic rd,
                      input logic redir, input logic [31:0] rpc);
    logic        exp_ce;
    logic        exp_valid;
    logic [31:0] exp_hpc;
    logic [31:0] exp_hdata;
    logic        do_pop;
    logic        issue;
    exp_ce    = !m_busy && (m_q.size() < DEPTH);
    exp_valid = (m_q.size() != 0);
    exp_hpc   = exp_valid ? m_q[0].pc : 32'h0;
    exp_hdata = exp_valid ? m_q[0].data : 32'h0;
    n_vec++;
    if (SRAM_INST_CE !== exp_ce || SRAM_INST_VADDR !== m_pc || INST_VALID !== exp_valid ||
        (exp_valid && (INST_PC !== exp_hpc || INST_DATA !== exp_hdata))) begin
      n_err++;
      $display("FAIL cycle_outputs t=%0t: got ce=%b vaddr=%h valid=%b pc=%h data=%h, want ce=%b vaddr=%h valid=%b pc=%h data=%h",
               $time, SRAM_INST_CE, SRAM_INST_VADDR, INST_VALID, INST_PC, INST_DATA,
               exp_ce, m_pc, exp_valid, exp_hpc, exp_hdata);
    end
    SRAM_INST_GNT    = gnt;
    SRAM_INST_RVALID = rv;
    SRAM_INST_RDATA  = $urandom;
    INST_READY       = rd;
    REDIRECT_VALID   = redir;
    REDIRECT_PC      = rpc;
    do_pop = exp_valid && rd;
    issue  = exp_ce && gnt;
    if (do_pop && !redir) void'(m_q.pop_front());
    if (m_busy && rv) begin
      if (!m_stale && !redir) m_q.push_back({m_inflight, SRAM_INST_RDATA});
      m_busy = 1'b0;
    end else if (m_busy && redir) begin
      m_stale = 1'b1;
    end
    if (redir) m_q.delete();
    if (issue) begin
      m_busy     = 1'b1;
      m_stale    = redir;
      m_inflight = m_pc;
      m_pc       = m_pc + 32'd4;
    end
    if (redir) m_pc = {rpc[31:2], 2'b00};
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #1;
    n_vec++;
    if (SRAM_INST_CE !== 1'b0 || INST_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: ce=%b valid=%b, want 0/0", SRAM_INST_CE, INST_VALID);
    end
    do_reset();
    n_vec++;
    if (SRAM_INST_CE !== 1'b1 || SRAM_INST_VADDR !== 32'hBFC0_0000) begin
      n_err++;
      $display("FAIL reset_release: ce=%b vaddr=%h, want 1/bfc00000", SRAM_INST_CE, SRAM_INST_VADDR);
    end
  endtask

  task automatic test_in_order();
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    logic [31:0] sent[$];
    logic        rv;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (INST_VALID === 1'b1) begin
        got_pc.push_back(INST_PC);
        got_data.push_back(INST_DATA);
      end
      rv = m_busy;
      step(1'b1, rv, 1'b1, 1'b0, 32'h0);
      if (rv) sent.push_back(SRAM_INST_RDATA);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (got_pc.size() <= i || sent.size() <= i) begin
        n_err++;
        $display("FAIL in_order_count: only %0d heads seen, want entry %0d", got_pc.size(), i);
      end else if (got_pc[i] !== RST_PC + 32'(4 * i) || got_data[i] !== sent[i]) begin
        n_err++;
        $display("FAIL in_order_%0d: pc=%h data=%h, want pc=%h data=%h",
                 i, got_pc[i], got_data[i], RST_PC + 32'(4 * i), sent[i]);
      end
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, m_busy, 1'b0, 1'b0, 32'h0);
    n_vec++;
    if (SRAM_INST_CE !== 1'b0 || INST_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL full_stall: ce=%b valid=%b, want 0/1", SRAM_INST_CE, INST_VALID);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++;
    if (SRAM_INST_CE !== 1'b1) begin
      n_err++;
      $display("FAIL ce_reassert: ce=%b, want 1", SRAM_INST_CE);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++;
    if (INST_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: valid=%b, want 0 after 4 pops", INST_VALID);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0100);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++;
    if (INST_VALID !== 1'b0 || SRAM_INST_CE !== 1'b1 || SRAM_INST_VADDR !== 32'h8000_0100) begin
      n_err++;
      $display("FAIL redirect_wait: valid=%b ce=%b vaddr=%h, want 0/1/80000100",
               INST_VALID, SRAM_INST_CE, SRAM_INST_VADDR);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++;
    if (INST_VALID !== 1'b1 || INST_PC !== 32'h8000_0100) begin
      n_err++;
      $display("FAIL redirect_first_pc: valid=%b pc=%h, want 1/80000100", INST_VALID, INST_PC);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0200);
    n_vec++;
    if (INST_VALID !== 1'b0 || SRAM_INST_CE !== 1'b1 || SRAM_INST_VADDR !== 32'h8000_0200) begin
      n_err++;
      $display("FAIL redirect_rvalid: valid=%b ce=%b vaddr=%h, want 0/1/80000200",
               INST_VALID, SRAM_INST_CE, SRAM_INST_VADDR);
    end
  endtask

  task automatic test_unaligned_and_wrap();
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0102);
    n_vec++;
    if (SRAM_INST_VADDR !== 32'h8000_0100) begin
      n_err++;
      $display("FAIL unaligned_redirect: vaddr=%h, want 80000100", SRAM_INST_VADDR);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++;
    if (SRAM_INST_VADDR !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL pc_wrap: vaddr=%h, want 00000000", SRAM_INST_VADDR);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    RST = 1'b0;
    #1;
    n_vec++;
    if (SRAM_INST_CE !== 1'b0 || INST_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_wait: ce=%b valid=%b, want 0/0", SRAM_INST_CE, INST_VALID);
    end
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    #1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++;
    if (INST_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL late_rvalid: valid=%b, want 0", INST_VALID);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic        gnt, rv, rd, redir;
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      gnt   = ($urandom_range(0, 3) != 0);
      rv    = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      rd    = ($urandom_range(0, 3) != 0) && (i % 200 > 40);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(gnt, rv, rd, redir, rpc);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_in_order();
    test_fill_drain();
    test_redirect_wait();
    test_redirect_rvalid();
    test_unaligned_and_wrap();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_q.md
IF_FETCH_Q -- requirements
Module: if_fetch_q

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC/address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning instruction width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning fetch-queue entries; power of 2, >=2.
REQ-004 The block SHALL have parameter RESET_PC, default 32'hBFC0_0000, meaning PC after reset.
REQ-005 CLK  in  1  clock; all state updates on the rising edge.
REQ-006 RST  in  1  reset; asynchronous, active-low.
REQ-007 REDIRECT_VALID  in  1  branch/exception redirect request.
REQ-008 REDIRECT_PC  in  ADDR_W  redirect target.
REQ-009 SRAM_INST_CE  out  1  fetch request valid.
REQ-010 SRAM_INST_VADDR  out  ADDR_W  fetch address.
REQ-011 SRAM_INST_GNT  in  1  request accepted this cycle.
REQ-012 SRAM_INST_RVALID  in  1  read data valid.
REQ-013 SRAM_INST_RDATA  in  DATA_W  read data.
REQ-014 INST_VALID  out  1  queue head valid to decode.
REQ-015 INST_READY  in  1  decode accepts the head.
REQ-016 INST_PC  out  ADDR_W  PC of the head.
REQ-017 INST_DATA  out  DATA_W  instruction of the head.

Function
REQ-018 The block SHALL use a three-state FSM: FETCH, WAIT and DISCARD, with at most one SRAM request outstanding.
REQ-019 SRAM_INST_CE SHALL equal (state==FETCH) && (count<DEPTH); SRAM_INST_VADDR SHALL equal the fetch PC register.
REQ-020 FETCH with CE && GNT SHALL capture the fetch PC as the in-flight PC, advance the fetch PC by 4 (modulo 2^ADDR_W), and enter WAIT.
REQ-021 WAIT with RVALID SHALL push {in-flight PC, RDATA} and return to FETCH; the push SHALL never overflow, because issue requires count<DEPTH.
REQ-022 A head handshake (INST_VALID && INST_READY) SHALL pop one entry; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-023 INST_VALID SHALL equal (count!=0); INST_PC and INST_DATA SHALL be the head entry, combinational from the queue.
REQ-024 REDIRECT_VALID SHALL set the fetch PC to {REDIRECT_PC[ADDR_W-1:2], 2'b00} and flush the queue (count=0 next cycle); a pop in the same cycle SHALL be ignored.
REQ-025 Redirect in FETCH with CE && GNT the same cycle SHALL enter DISCARD.
REQ-026 Redirect in FETCH with no grant SHALL stay in FETCH.
REQ-027 Redirect in WAIT without RVALID SHALL enter DISCARD.
REQ-028 Redirect in WAIT with RVALID SHALL drop the data and enter FETCH.
REQ-029 Redirect in DISCARD without RVALID SHALL update the PC and stay in DISCARD.
REQ-030 Redirect in DISCARD with RVALID SHALL update the PC and enter FETCH.
REQ-031 DISCARD with RVALID and no redirect SHALL drop the data and enter FETCH; nothing SHALL be pushed.
REQ-032 RVALID in FETCH SHALL be ignored.
REQ-033 Redirect SHALL take priority over the sequential PC+4 update.

Reset
REQ-034 While RST=0, the block SHALL set state=FETCH, fetch PC=RESET_PC, count=0, read/write pointers=0, SRAM_INST_CE=0 and INST_VALID=0, immediately and independent of CLK.
REQ-035 Reset asserted mid-WAIT SHALL abandon the request; a late RVALID after release, arriving in FETCH, SHALL be ignored.
REQ-036 On the first edge after release, SRAM_INST_CE SHALL be 1 with SRAM_INST_VADDR=RESET_PC.

Structure
REQ-037 Shared package if_pkg SHALL hold the FSM state enum and the RESET_PC and DEPTH defaults.
REQ-038 The queue SHALL be the sub-module inst_fifo: synchronous, with flush, parameterised by width and DEPTH, and exposing count.

Verification (DEPTH=4, RESET_PC=BFC0_0000)
REQ-039 Release reset, GNT=1, RVALID one cycle after GNT, READY=1 -> INST_PC BFC0_0000, BFC0_0004, BFC0_0008 in order, with matching RDATA.
REQ-040 READY=0 -> exactly 4 entries pushed, then CE=0 with count=4; READY=1 -> one pop per cycle, and CE re-asserts next cycle.
REQ-041 Redirect to 8000_0100 in WAIT, RVALID two cycles later -> that data dropped, queue empty, next request VADDR=8000_0100, first INST_PC=8000_0100.
REQ-042 Redirect to 8000_0200 coincident with RVALID in WAIT -> no push, next VADDR=8000_0200.
REQ-043 Redirect to 8000_0102 -> VADDR=8000_0100.
REQ-044 Fetch PC FFFF_FFFC granted -> next VADDR=0000_0000.
REQ-045 RST=0 mid-WAIT -> CE=0 and INST_VALID=0 immediately; RVALID pulse after release -> no entry pushed.
